// File: rtl/branch_hazard_unit.sv
// Forwarding select and stall control for branches resolved in ID, with a saturating
// counter of the stall cycles that branches cause.
module branch_hazard_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IFID_Is_Branch,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] IFID_Reg_RS,
  input  logic [NUM_SRC-1:0]            IFID_RS_Used,
  input  logic [REG_ADDR_W-1:0]         IDEX_Reg_RD,
  input  logic                          IDEX_RegWrite,
  input  logic                          IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0]         EXMEM_Reg_RD,
  input  logic                          EXMEM_RegWrite,
  input  logic                          EXMEM_MemToReg,
  input  logic [REG_ADDR_W-1:0]         MEMWB_Reg_RD,
  input  logic                          MEMWB_RegWrite,
  input  logic                          Flush,
  output logic [2*NUM_SRC-1:0]          Fwd_Sel,
  output logic                          Stall,
  output logic [STALL_CNT_W-1:0]        Stall_Count
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [NUM_SRC-1:0] match_idex;
  logic [NUM_SRC-1:0] match_exmem;
  logic [NUM_SRC-1:0] match_memwb;
  logic               fwd_en;

  assign fwd_en = IFID_Is_Branch && !rst;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic                  rs_live;

    assign rs      = IFID_Reg_RS[gi*REG_ADDR_W +: REG_ADDR_W];
    // x0 is hard-wired zero, so it never creates a dependency
    assign rs_live = IFID_RS_Used[gi] && (rs != '0);

    assign match_idex[gi]  = rs_live && IDEX_RegWrite  && (IDEX_Reg_RD  == rs);
    assign match_exmem[gi] = rs_live && EXMEM_RegWrite && (EXMEM_Reg_RD == rs);
    assign match_memwb[gi] = rs_live && MEMWB_RegWrite && (MEMWB_Reg_RD == rs);

    assign Fwd_Sel[2*gi +: 2] = !fwd_en                                ? 2'b00 :
                                (match_exmem[gi] && !EXMEM_MemToReg)   ? 2'b01 :
                                match_memwb[gi]                        ? 2'b10 : 2'b00;
  end

  logic need_two;
  logic need_any;

  assign need_two = (|match_idex) && IDEX_MemRead;
  assign need_any = (|match_idex) || ((|match_exmem) && EXMEM_MemToReg);

  logic [0:0]             state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Stall   = 1'b0;
    if (rst) begin
      Stall = 1'b0;
    end else if (Flush) begin
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          Stall = IFID_Is_Branch && need_any;
          // A single-cycle hazard stays in IDLE and is re-checked once the producer moves
          if (IFID_Is_Branch && need_two) begin
            state_d = ST_STALL;
            cnt_d   = 2'd1;
          end
        end
        ST_STALL: begin
          Stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed and random checks of branch_hazard_unit against a cycle-count reference model.
module tb_branch_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_branch;
  logic [9:0]  rs;
  logic [1:0]  rs_used;
  logic [4:0]  idex_rd, exmem_rd, memwb_rd;
  logic        idex_rw, idex_mr, exmem_rw, exmem_m2r, memwb_rw, flush;
  logic [3:0]  fwd, fwd_s;
  logic        stall, stall_s;
  logic [15:0] cnt;
  logic [2:0]  cnt_s;

  int checks = 0;
  int failures = 0;

  // reference model state
  int  rem = 0;
  int  exp_cnt = 0;
  int  exp_cnt_s = 0;
  bit  cnt_known = 0;
  bit  exp_stall;

  always #5 clk = ~clk;

  branch_hazard_unit dut (
    .clk(clk), .rst(rst), .IFID_Is_Branch(is_branch), .IFID_Reg_RS(rs),
    .IFID_RS_Used(rs_used), .IDEX_Reg_RD(idex_rd), .IDEX_RegWrite(idex_rw),
    .IDEX_MemRead(idex_mr), .EXMEM_Reg_RD(exmem_rd), .EXMEM_RegWrite(exmem_rw),
    .EXMEM_MemToReg(exmem_m2r), .MEMWB_Reg_RD(memwb_rd), .MEMWB_RegWrite(memwb_rw),
    .Flush(flush), .Fwd_Sel(fwd), .Stall(stall), .Stall_Count(cnt)
  );

  branch_hazard_unit #(.STALL_CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .IFID_Is_Branch(is_branch), .IFID_Reg_RS(rs),
    .IFID_RS_Used(rs_used), .IDEX_Reg_RD(idex_rd), .IDEX_RegWrite(idex_rw),
    .IDEX_MemRead(idex_mr), .EXMEM_Reg_RD(exmem_rd), .EXMEM_RegWrite(exmem_rw),
    .EXMEM_MemToReg(exmem_m2r), .MEMWB_Reg_RD(memwb_rd), .MEMWB_RegWrite(memwb_rw),
    .Flush(flush), .Fwd_Sel(fwd_s), .Stall(stall_s), .Stall_Count(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int need_cycles();
    int n = 0;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] r;
      r = rs[i*5 +: 5];
      if (rs_used[i] && r != 0) begin
        if (idex_rw && idex_rd == r) n = (idex_mr || n == 2) ? 2 : 1;
        else if (exmem_rw && exmem_m2r && exmem_rd == r && n == 0) n = 1;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] model_fwd();
    logic [3:0] f = 4'b0;
    if (rst || !is_branch) return f;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] r;
      r = rs[i*5 +: 5];
      if (rs_used[i] && r != 0) begin
        if (exmem_rw && !exmem_m2r && exmem_rd == r) f[i*2 +: 2] = 2'b01;
        else if (memwb_rw && memwb_rd == r)          f[i*2 +: 2] = 2'b10;
      end
    end
    return f;
  endfunction

  // Compare outputs half a cycle before the rising edge.
  task automatic sample(input string tag);
    @(negedge clk);
    if (rst || flush)   exp_stall = 0;
    else if (rem > 0)   exp_stall = 1;
    else                exp_stall = is_branch && need_cycles() > 0;
    check({tag, ".fwd"}, {28'b0, fwd}, {28'b0, model_fwd()});
    check({tag, ".stall"}, {31'b0, stall}, {31'b0, exp_stall});
    check({tag, ".fwd_s"}, {28'b0, fwd_s}, {28'b0, model_fwd()});
    check({tag, ".stall_s"}, {31'b0, stall_s}, {31'b0, exp_stall});
    if (cnt_known) begin
      check({tag, ".cnt"}, {16'b0, cnt}, exp_cnt);
      check({tag, ".cnt_s"}, {29'b0, cnt_s}, exp_cnt_s);
    end
  endtask

  task automatic advance();
    int n;
    n = need_cycles();
    @(posedge clk);
    if (rst) begin
      rem = 0; exp_cnt = 0; exp_cnt_s = 0; cnt_known = 1;
    end else begin
      if (exp_stall) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt_s < 7) exp_cnt_s++;
      end
      if (flush)                       rem = 0;
      else if (rem > 0)                rem--;
      else if (is_branch && n == 2)    rem = 1;
    end
    #1;
  endtask

  task automatic clr();
    rst = 0; is_branch = 1; rs = {5'd6, 5'd5}; rs_used = 2'b11;
    idex_rd = 0; idex_rw = 0; idex_mr = 0;
    exmem_rd = 0; exmem_rw = 0; exmem_m2r = 0;
    memwb_rd = 0; memwb_rw = 0; flush = 0;
  endtask

  initial begin
    // reset with a live hazard present: outputs must stay quiet
    clr(); rst = 1; idex_rd = 5; idex_rw = 1; memwb_rd = 6; memwb_rw = 1;
    sample("reset0"); advance();
    sample("reset1");
    check("reset.stall0", {31'b0, stall}, 0);
    check("reset.fwd0", {28'b0, fwd}, 0);
    advance();

    clr(); memwb_rd = 5; memwb_rw = 1;
    sample("memwb");
    check("memwb.fwd_const", {28'b0, fwd}, 32'b0010);
    check("reset.cnt_const", {16'b0, cnt}, 0);
    advance();

    clr(); exmem_rd = 5; exmem_rw = 1; memwb_rd = 5; memwb_rw = 1;
    sample("exmem_prio");
    check("exmem_prio.const", {30'b0, fwd[1:0]}, 32'b01);
    advance();
    rs[4:0] = 0;
    sample("x0");
    check("x0.const", {30'b0, fwd[1:0]}, 0);
    advance();

    clr(); idex_rd = 6; idex_rw = 1;
    sample("alu0");
    check("alu0.stall_const", {31'b0, stall}, 1);
    advance();
    clr(); exmem_rd = 6; exmem_rw = 1;
    sample("alu1");
    check("alu1.fwd_const", {30'b0, fwd[3:2]}, 32'b01);
    check("alu1.cnt_const", {16'b0, cnt}, 1);
    advance();

    clr(); idex_rd = 5; idex_rw = 1; idex_mr = 1;
    sample("load0"); advance();
    clr(); exmem_rd = 5; exmem_rw = 1; exmem_m2r = 1;
    sample("load1");
    check("load1.stall_const", {31'b0, stall}, 1);
    advance();
    clr(); memwb_rd = 5; memwb_rw = 1;
    sample("load2");
    check("load2.fwd_const", {30'b0, fwd[1:0]}, 32'b10);
    check("load2.cnt_const", {16'b0, cnt}, 3);
    advance();

    clr(); idex_rd = 5; idex_rw = 1; idex_mr = 1;
    sample("flush0"); advance();
    clr(); exmem_rd = 5; exmem_rw = 1; exmem_m2r = 1; flush = 1;
    sample("flush1");
    check("flush1.stall_const", {31'b0, stall}, 0);
    advance();
    clr();
    sample("flush2");
    check("flush2.cnt_const", {16'b0, cnt}, 4);
    advance();

    clr(); idex_rd = 5; idex_rw = 1; idex_mr = 1;
    sample("rstmid0"); advance();
    clr(); rst = 1;
    sample("rstmid1"); advance();
    clr();
    sample("rstmid2");
    check("rstmid2.cnt_const", {16'b0, cnt}, 0);
    advance();

    for (int i = 0; i < 10; i++) begin
      clr(); idex_rd = 6; idex_rw = 1;
      sample("sat"); advance();
    end
    clr();
    sample("sat_end");
    check("sat.cnt_s_const", {29'b0, cnt_s}, 7);
    check("sat.cnt_const", {16'b0, cnt}, 10);
    advance();

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 40) == 0);
      flush     = ($urandom_range(0, 12) == 0);
      is_branch = ($urandom_range(0, 3) != 0);
      rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_used   = 2'($urandom_range(0, 3));
      idex_rd   = 5'($urandom_range(0, 3)); idex_rw = 1'($urandom); idex_mr = 1'($urandom);
      exmem_rd  = 5'($urandom_range(0, 3)); exmem_rw = 1'($urandom);
      exmem_m2r = 1'($urandom);
      memwb_rd  = 5'($urandom_range(0, 3)); memwb_rw = 1'($urandom);
      sample("rand"); advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_hazard_unit.md
Name: branch_hazard_unit

Overview:
Parametrised forwarding and stall controller for branches resolved in the ID stage of the rv32 pipeline. It selects, per branch source operand, the freshest value: register file, EX/MEM ALU result, or MEM/WB writeback. It also runs a stall FSM that holds IF/ID and bubbles ID/EX when a producer's result cannot yet be forwarded (ALU op in EX, load in EX or MEM). A saturating counter records stall cycles caused by branches, for performance measurement.

Parameters:
REG_ADDR_W, 5, register index width
NUM_SRC, 2, number of branch source operands checked (compare and jump-register use 1 or 2)
STALL_CNT_W, 16, width of the saturating branch-stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
IFID_Is_Branch  in  1  instruction in ID is a branch or JALR that resolves in ID
IFID_Reg_RS  in  NUM_SRC*REG_ADDR_W  source indices; operand i occupies bits [i*REG_ADDR_W +: REG_ADDR_W]
IFID_RS_Used  in  NUM_SRC  per-operand valid
IDEX_Reg_RD  in  REG_ADDR_W  destination in EX
IDEX_RegWrite  in  1  EX instruction writes rd
IDEX_MemRead  in  1  EX instruction is a load
EXMEM_Reg_RD  in  REG_ADDR_W  destination in MEM
EXMEM_RegWrite  in  1  MEM instruction writes rd
EXMEM_MemToReg  in  1  MEM instruction is a load
MEMWB_Reg_RD  in  REG_ADDR_W  destination in WB
MEMWB_RegWrite  in  1  WB instruction writes rd
Flush  in  1  pipeline flush (taken branch, trap); aborts a stall
Fwd_Sel  out  2*NUM_SRC  per-operand mux select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result, 11 unused
Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
Stall_Count  out  STALL_CNT_W  saturating count of branch stall cycles

Behaviour:
- Match rule per operand i: match_X = RS_Used[i] && RS[i] != 0 && X_RegWrite && X_Reg_RD == RS[i]. x0 is never forwarded or stalled on.
- Fwd_Sel (combinational, every cycle, independent of Stall):
  - 01 if EX/MEM matches and EXMEM_MemToReg = 0.
  - Else 10 if MEM/WB matches.
  - Else 00.
  - EX/MEM takes priority over MEM/WB.
  - Fwd_Sel is valid only while IFID_Is_Branch = 1. It is driven to 00 for every operand when IFID_Is_Branch = 0.
- Stall cycles needed N, evaluated only when IFID_Is_Branch = 1, taking the maximum over all operands:
  - 2 if ID/EX matches with IDEX_MemRead = 1.
  - Else 1 if ID/EX matches (ALU producer).
  - Else 1 if EX/MEM matches with EXMEM_MemToReg = 1.
  - Else 0.
- FSM states:
  - IDLE, remaining count cnt = 0.
  - STALL, cnt > 0.
- IDLE:
  - Stall = (IFID_Is_Branch && N > 0 && !Flush).
  - If N = 2, go to STALL with cnt = 1.
  - If N = 1, the single stall cycle is this one; remain in IDLE. The hazard is re-evaluated next cycle, when the producer has advanced.
- STALL:
  - Stall = 1.
  - cnt decrements each cycle; at cnt = 1 the next state is IDLE.
  - Inputs are not re-evaluated while in STALL.
- Flush:
  - In any state, the next state is IDLE and cnt = 0.
  - Stall is forced to 0 in the same cycle (Flush wins over a new detection).
- Stall_Count:
  - Increments by 1 on every clock edge where Stall = 1.
  - Saturates at all-ones; no wrap.
- Reset:
  - rst = 1 on a clock edge forces IDLE, cnt = 0, Stall_Count = 0.
  - Stall and Fwd_Sel are 0 during reset.
  - Reset asserted mid-stall abandons the stall immediately; Stall = 0 from the cycle after the edge.
- Simultaneous events:
  - One operand needing 2 cycles and the other needing 1 yields 2 cycles.
  - With both operands equal, each operand gets the same Fwd_Sel.
- Latency:
  - Fwd_Sel and Stall are combinational from inputs and state.
  - State and counter update on the rising edge of clk.

Test Plan:
- MEM/WB forward: branch RS = {5, 6}; MEMWB_Reg_RD = 5, MEMWB_RegWrite = 1; no other matches -> Fwd_Sel = 2'b00_10, Stall = 0.
- EX/MEM priority: EXMEM_Reg_RD = 5 and MEMWB_Reg_RD = 5, both writing, not a load -> Fwd_Sel[1:0] = 01. Repeat with RS = 0 -> 00.
- ALU producer in EX: IDEX_Reg_RD = 6, RegWrite = 1, MemRead = 0 -> Stall = 1 for exactly 1 cycle. The next cycle advances the producer to EX/MEM -> Fwd_Sel[3:2] = 01, Stall = 0, Stall_Count = 1.
- Load producer in EX: IDEX_MemRead = 1, RD = 5 -> Stall high 2 consecutive cycles (the second in STALL). The producer then sits in MEM/WB -> Fwd_Sel = 10, Stall_Count = 2.
- Flush mid-stall: load-use stall started, Flush = 1 in the second cycle -> Stall = 0 that cycle, state IDLE next, Stall_Count = 1.
- Reset mid-stall and saturation: rst during STALL -> Stall = 0 and Stall_Count = 0 next cycle. With STALL_CNT_W = 3, 10 stall cycles -> Stall_Count holds 7.
